// File: rtl/bus_pkg.sv
// Shared widths and helpers for the per-terminal bus port buffering stage.
package bus_pkg;

    localparam int unsigned PCKG_SZ_DEF = 16;
    localparam int unsigned DEPTH_DEF   = 8;

    typedef logic [PCKG_SZ_DEF-1:0] pkt_t;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered overflow/underflow pulses.
// Depth need not be a power of two; pointers wrap explicitly at depth-1.
module sync_fifo
    import bus_pkg::*;
#(
    parameter int unsigned width = PCKG_SZ_DEF,
    parameter int unsigned depth = DEPTH_DEF,
    localparam int unsigned CW   = cnt_w(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] wdata,
    input  logic             rd,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned   PW       = $clog2(depth);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);
    localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_unf;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_rd_ok = rd & ~empty;
    assign w_wr_ok = wr & (~full | w_rd_ok);

    // Head reads as zero while empty so stale storage never leaks out after reset.
    assign rdata = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
            r_ovf   <= wr & full & ~w_rd_ok;
            r_unf   <= rd & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= wdata;
        end
    end

endmodule

// File: rtl/bus_port_fifo.sv
// Per-terminal TX/RX buffering between one agent and one bus port.
// TX is filled by the agent and drained by the bus; RX is the reverse.
module bus_port_fifo
    import bus_pkg::*;
#(
    parameter int unsigned pckg_sz = PCKG_SZ_DEF,
    parameter int unsigned depth   = DEPTH_DEF,
    parameter int unsigned drv_id  = 0,
    localparam int unsigned CW     = cnt_w(depth)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic [CW-1:0]      tx_count,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_empty,
    output logic [CW-1:0]      rx_count,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               tx_ovf,
    output logic               rx_ovf,
    output logic               unf
);

    logic w_tx_empty;
    logic w_tx_unf;
    logic w_rx_full;
    logic w_rx_unf;
    logic w_unused_drv_id;

    // drv_id only labels the instance; it carries no logic.
    assign w_unused_drv_id = ^drv_id;

    sync_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .full  (tx_full),
        .empty (w_tx_empty),
        .count (tx_count),
        .ovf   (tx_ovf),
        .unf   (w_tx_unf)
    );

    sync_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx (
        .clk   (clk),
        .reset (reset),
        .wr    (push),
        .wdata (D_push),
        .rd    (rx_rd),
        .rdata (rx_data),
        .full  (w_rx_full),
        .empty (rx_empty),
        .count (rx_count),
        .ovf   (rx_ovf),
        .unf   (w_rx_unf)
    );

    assign pndng = ~w_tx_empty;
    assign unf   = w_tx_unf | w_rx_unf;

endmodule

// File: tb/tb_bus_port_fifo.sv
// Self-checking bench for bus_port_fifo: directed scenarios plus randomized traffic
// checked against queue-based TX/RX models.
module tb_bus_port_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_wr;
    logic [15:0]   tx_data;
    logic          tx_full;
    logic [CW-1:0] tx_count;
    logic          rx_rd;
    logic [15:0]   rx_data;
    logic          rx_empty;
    logic [CW-1:0] rx_count;
    logic          pndng;
    logic [15:0]   D_pop;
    logic          pop;
    logic          push;
    logic [15:0]   D_push;
    logic          tx_ovf;
    logic          rx_ovf;
    logic          unf;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_tx[$];
    logic [15:0] exp_rx[$];
    bit          e_tx_ovf;
    bit          e_rx_ovf;
    bit          e_unf;

    always #5 clk = ~clk;

    bus_port_fifo #(
        .pckg_sz (16),
        .depth   (DEPTH),
        .drv_id  (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .tx_count (tx_count),
        .rx_rd    (rx_rd),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_count (rx_count),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .tx_ovf   (tx_ovf),
        .rx_ovf   (rx_ovf),
        .unf      (unf)
    );

    // Advance the model by one edge using the currently driven inputs, then clock the DUT.
    task automatic tick();
        bit          tx_rd_ok;
        bit          rx_rd_ok;
        logic [15:0] dropped;
        if (reset) begin
            exp_tx.delete();
            exp_rx.delete();
            e_tx_ovf = 0;
            e_rx_ovf = 0;
            e_unf    = 0;
        end else begin
            tx_rd_ok = pop && exp_tx.size() > 0;
            rx_rd_ok = rx_rd && exp_rx.size() > 0;
            e_unf    = (pop && exp_tx.size() == 0) || (rx_rd && exp_rx.size() == 0);
            e_tx_ovf = tx_wr && exp_tx.size() == DEPTH && !tx_rd_ok;
            e_rx_ovf = push && exp_rx.size() == DEPTH && !rx_rd_ok;
            if (tx_rd_ok) dropped = exp_tx.pop_front();
            if (rx_rd_ok) dropped = exp_rx.pop_front();
            if (tx_wr && !e_tx_ovf) exp_tx.push_back(tx_data);
            if (push && !e_rx_ovf) exp_rx.push_back(D_push);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset   = 0;
        tx_wr   = 0;
        tx_data = '0;
        rx_rd   = 0;
        pop     = 0;
        push    = 0;
        D_push  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset   = 1;
        tx_wr   = 1;
        tx_data = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (pndng !== 1'b0 || tx_count !== '0 || rx_empty !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_hold[%0d]: pndng=%b tx_count=%0d rx_empty=%b want 0/0/1",
                         i, pndng, tx_count, rx_empty);
            end
            n_checks++;
            if (tx_ovf !== 1'b0 || rx_ovf !== 1'b0 || unf !== 1'b0 || D_pop !== 16'h0
                || rx_data !== 16'h0) begin
                n_errors++;
                $display("FAIL reset_outs[%0d]: ovf=%b/%b unf=%b D_pop=%h rx_data=%h want zeros",
                         i, tx_ovf, rx_ovf, unf, D_pop, rx_data);
            end
        end
        reset   = 0;
        tx_data = 16'h1234;
        tick();
        n_checks++;
        if (pndng !== 1'b1 || tx_count !== 4'd1 || D_pop !== 16'h1234) begin
            n_errors++;
            $display("FAIL reset_first_write: pndng=%b tx_count=%0d D_pop=%h want 1/1/1234",
                     pndng, tx_count, D_pop);
        end
        tx_wr = 0;
        pop   = 1;
        tick();
        pop = 0;
        n_checks++;
        if (pndng !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_drain: pndng=%b want 0", pndng);
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        tx_wr = 1;
        for (int i = 0; i < 8; i++) begin
            tx_data = 16'h1001 + 16'(i);
            tick();
            n_checks++;
            if (tx_count !== CW'(i + 1)) begin
                n_errors++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, tx_count, i + 1);
            end
        end
        n_checks++;
        if (tx_full !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_full: got %b want 1", tx_full);
        end
        tx_data = 16'h1009;
        tick();
        tx_wr = 0;
        n_checks++;
        if (tx_ovf !== 1'b1 || tx_count !== 4'd8) begin
            n_errors++;
            $display("FAIL fill_ovf: tx_ovf=%b count=%0d want 1/8", tx_ovf, tx_count);
        end
        tick();
        n_checks++;
        if (tx_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_nonsticky: got %b want 0", tx_ovf);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (D_pop !== 16'h1001 + 16'(i)) begin
                n_errors++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, D_pop, 16'h1001 + 16'(i));
            end
            pop = 1;
            tick();
            pop = 0;
        end
        n_checks++;
        if (pndng !== 1'b0 || tx_count !== '0) begin
            n_errors++;
            $display("FAIL drain_empty: pndng=%b count=%0d want 0/0", pndng, tx_count);
        end
    endtask

    task automatic test_full_simul();
        logic [15:0] seen;
        do_reset();
        tx_wr = 1;
        for (int i = 0; i < 8; i++) begin
            tx_data = 16'($urandom);
            tick();
        end
        tx_data = 16'hAAAA;
        pop     = 1;
        tick();
        tx_wr = 0;
        pop   = 0;
        n_checks++;
        if (tx_ovf !== 1'b0 || tx_count !== 4'd8 || tx_full !== 1'b1) begin
            n_errors++;
            $display("FAIL full_simul: ovf=%b count=%0d full=%b want 0/8/1",
                     tx_ovf, tx_count, tx_full);
        end
        for (int i = 0; i < 8; i++) begin
            seen = D_pop;
            n_checks++;
            if (seen !== exp_tx[0]) begin
                n_errors++;
                $display("FAIL full_simul_data[%0d]: got %h want %h", i, seen, exp_tx[0]);
            end
            pop = 1;
            tick();
            pop = 0;
        end
        n_checks++;
        if (seen !== 16'hAAAA || pndng !== 1'b0) begin
            n_errors++;
            $display("FAIL full_simul_last: last=%h pndng=%b want aaaa/0", seen, pndng);
        end
    endtask

    task automatic test_empty_simul();
        do_reset();
        push   = 1;
        D_push = 16'h5555;
        rx_rd  = 1;
        tick();
        push  = 0;
        rx_rd = 0;
        n_checks++;
        if (unf !== 1'b1 || rx_count !== 4'd1 || rx_data !== 16'h5555 || rx_empty !== 1'b0) begin
            n_errors++;
            $display("FAIL empty_simul: unf=%b count=%0d data=%h empty=%b want 1/1/5555/0",
                     unf, rx_count, rx_data, rx_empty);
        end
        rx_rd = 1;
        tick();
        rx_rd = 0;
        n_checks++;
        if (unf !== 1'b0 || rx_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL empty_simul_drain: unf=%b empty=%b want 0/1", unf, rx_empty);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            d      = 16'($urandom);
            push   = 1;
            D_push = d;
            tick();
            push = 0;
            n_checks++;
            if (rx_data !== d || rx_count !== 4'd1) begin
                n_errors++;
                $display("FAIL wrap_data[%0d]: got %h/%0d want %h/1", i, rx_data, rx_count, d);
            end
            rx_rd = 1;
            tick();
            rx_rd = 0;
        end
        n_checks++;
        if (rx_count !== '0 || rx_empty !== 1'b1 || unf !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_end: count=%0d empty=%b unf=%b want 0/1/0", rx_count, rx_empty, unf);
        end
    endtask

    task automatic test_random();
        int          p_wr;
        logic [15:0] e_dpop;
        logic [15:0] e_rxd;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            // Alternate write-heavy and read-heavy phases so both FIFOs hit full and empty.
            p_wr    = ((c / 75) % 2 == 0) ? 75 : 25;
            reset   = (c == 300);
            tx_wr   = $urandom_range(0, 99) < p_wr;
            pop     = $urandom_range(0, 99) < (100 - p_wr);
            push    = $urandom_range(0, 99) < p_wr;
            rx_rd   = $urandom_range(0, 99) < (100 - p_wr);
            tx_data = 16'($urandom);
            D_push  = 16'($urandom);
            tick();
            e_dpop = (exp_tx.size() > 0) ? exp_tx[0] : 16'h0;
            e_rxd  = (exp_rx.size() > 0) ? exp_rx[0] : 16'h0;
            n_checks++;
            if (tx_count !== CW'(exp_tx.size()) || tx_full !== (exp_tx.size() == DEPTH)
                || pndng !== (exp_tx.size() != 0) || D_pop !== e_dpop) begin
                n_errors++;
                $display("FAIL rand_tx[%0d]: count=%0d full=%b pndng=%b D_pop=%h want %0d/%b/%b/%h",
                         c, tx_count, tx_full, pndng, D_pop, exp_tx.size(),
                         exp_tx.size() == DEPTH, exp_tx.size() != 0, e_dpop);
            end
            n_checks++;
            if (rx_count !== CW'(exp_rx.size()) || rx_empty !== (exp_rx.size() == 0)
                || rx_data !== e_rxd) begin
                n_errors++;
                $display("FAIL rand_rx[%0d]: count=%0d empty=%b data=%h want %0d/%b/%h",
                         c, rx_count, rx_empty, rx_data, exp_rx.size(), exp_rx.size() == 0, e_rxd);
            end
            n_checks++;
            if (tx_ovf !== e_tx_ovf || rx_ovf !== e_rx_ovf || unf !== e_unf) begin
                n_errors++;
                $display("FAIL rand_flags[%0d]: tx_ovf=%b rx_ovf=%b unf=%b want %b/%b/%b",
                         c, tx_ovf, rx_ovf, unf, e_tx_ovf, e_rx_ovf, e_unf);
            end
        end
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_full_simul();
        test_empty_simul();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
